onehot_decoder_seq: RTL
=======================

Name: onehot_decoder_seq

Overview:
Parametrised binary-to-one-hot decoder; the registered, handshaked successor to the team's fixed 4-to-16 combinational decoder.
- Direct mode: decodes a code word into a one-hot output word over a valid/ready stream with one output register stage.
- Sweep mode: walks a single hot bit across all outputs. Used for select-line, row and LED scan.
- Sits between a code source (FSM, counter, register) and a consumer that back-pressures.

Parameters:
NUM_OUT, 16, number of one-hot outputs; legal range 2..256.
IN_W, $clog2(NUM_OUT), code width; derived, must not be overridden.

Ports:
clk  input  1  rising-edge clock.
rst_n  input  1  asynchronous active-low reset.
mode  input  1  0 = direct decode, 1 = sweep; sampled only in IDLE.
in_valid  input  1  in_code valid (direct mode).
in_ready  output  1  block accepts in_code this cycle.
in_code  input  IN_W  binary code to decode.
sweep_start  input  1  single-cycle request to begin a sweep.
out_valid  output  1  out holds a valid word.
out_ready  input  1  consumer accepts out this cycle.
out  output  NUM_OUT  registered one-hot word.
busy  output  1  high while a sweep is in progress.

Behaviour:
- Reset (rst_n low, asynchronous):
  - out = 0, out_valid = 0, busy = 0.
  - State = IDLE; sweep index = 0.
  - Outputs stay at these values until the first rising clk after rst_n deasserts.
- States: IDLE, SWEEP. Output register full/empty is tracked by out_valid.
- Direct mode (IDLE, mode = 0):
  - in_ready = !out_valid || out_ready, i.e. a single-stage pipe that accepts on the same cycle it drains.
  - Accept when in_valid && in_ready. Next cycle: out = 1 << in_code, out_valid = 1. Latency 1 cycle; throughput 1 word/cycle with out_ready held high.
  - Illegal code (in_code >= NUM_OUT): accepted normally, out = all zeros, out_valid = 1.
  - out_valid && !out_ready: out and out_valid hold unchanged; in_ready = 0.
  - Output handshake with no new input: out_valid clears next cycle; out keeps its last value.
- Sweep entry (IDLE):
  - Condition: sweep_start = 1, mode = 1, and output empty or draining (!out_valid || out_ready).
  - Next cycle: state = SWEEP, busy = 1, out = 1 << 0, out_valid = 1.
  - sweep_start while the output is stalled is ignored, not queued.
  - sweep_start with mode = 0 is ignored.
- SWEEP:
  - in_ready = 0.
  - Each out handshake advances the index: out = 1 << (index + 1).
  - Handshake on index NUM_OUT-1: out_valid = 0 and busy = 0 next cycle; state returns to IDLE; out keeps its last value.
  - No wrap-around: exactly NUM_OUT words per sweep.
  - Stall (out_ready = 0): index, out and out_valid hold.
  - mode and sweep_start are ignored during SWEEP; changing mode takes effect only on return to IDLE.
- Simultaneous events:
  - In IDLE with mode = 1, in_valid is ignored and in_ready = 0, so sweep always has priority.
  - An input accept and an output handshake in the same cycle load the new word without a bubble.
- Reset mid-sweep: asynchronous return to reset values; the partial sweep is discarded.
- Invariant: out has at most one bit set whenever out_valid = 1.

Optional Feature:
Macro: ONEHOT_DECODER_ERR_EN
- Defined:
  - Adds output port code_err (1 bit), registered, reset 0.
  - code_err is set alongside out_valid when the accepted in_code >= NUM_OUT.
  - It holds with the word and clears with the next loaded word or when out_valid clears.
  - It is always 0 in sweep mode.
- Undefined: no code_err port. Illegal codes still give all-zero out with out_valid = 1.

Test Plan:
- Reset: assert rst_n = 0 mid-cycle -> out = 0, out_valid = 0, busy = 0 immediately, without waiting for a clk edge.
- Direct, NUM_OUT = 16, out_ready = 1: in_code = 0..15 back-to-back -> out = 0x0001..0x8000, one per cycle, latency 1, in_ready stays 1.
- Back-pressure: in_code = 5, then in_code = 9 with out_ready = 0 for 3 cycles -> out holds 0x0020, in_ready = 0 during the stall; after out_ready = 1, out = 0x0200.
- Sweep, NUM_OUT = 16: mode = 1, sweep_start pulse, out_ready toggling 1,0,1,... -> 16 words 0x0001..0x8000 in order, busy high throughout, then busy = 0 and out_valid = 0.
- NUM_OUT = 10, ERR_EN defined: in_code = 12 -> out = 0, out_valid = 1, code_err = 1; next in_code = 3 -> out = 0x008, code_err = 0.
- Reset mid-sweep at index 7 -> outputs return to reset values; a new sweep_start restarts at out = 0x0001.

Source files
------------

// File: rtl/onehot_decoder_seq.sv
// ---------------------------------------------------------------------------
// onehot_decoder_seq
//
// Registered binary-to-one-hot decoder with valid/ready handshakes on both
// sides. It has two modes of operation:
//   - direct mode (mode = 0): each accepted in_code appears one cycle later
//     as out = 1 << in_code. A code >= NUM_OUT gives an all-zero word.
//   - sweep mode  (mode = 1): a sweep_start pulse walks a single hot bit from
//     bit 0 up to bit NUM_OUT-1. The walk advances one position per output
//     handshake and produces exactly NUM_OUT words.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   mode         0 = direct decode, 1 = sweep (sampled only while idle)
//   in_valid     in_code is valid (direct mode)
//   in_ready     block accepts in_code this cycle
//   in_code      binary code to decode (IN_W bits)
//   sweep_start  single-cycle request to begin a sweep
//   out_valid    out holds a valid word
//   out_ready    consumer accepts out this cycle
//   out          registered one-hot word (NUM_OUT bits)
//   busy         high while a sweep is in progress
//   code_err     (only with ONEHOT_DECODER_ERR_EN) the word on out came from
//                an illegal code
//
// Optional feature macro: ONEHOT_DECODER_ERR_EN adds the code_err output.
// ---------------------------------------------------------------------------
module onehot_decoder_seq #(
    parameter int NUM_OUT = 16,
    parameter int IN_W    = $clog2(NUM_OUT)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               mode,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [IN_W-1:0]    in_code,
    input  logic               sweep_start,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [NUM_OUT-1:0] out,
    output logic               busy
`ifdef ONEHOT_DECODER_ERR_EN
    ,
    output logic               code_err
`endif
);

    typedef enum logic {
        IDLE,
        SWEEP
    } state_e;

    state_e             state_q, state_d;
    logic [NUM_OUT-1:0] out_q, out_d;
    logic               out_valid_q, out_valid_d;
    logic [IN_W-1:0]    idx_q, idx_d;
`ifdef ONEHOT_DECODER_ERR_EN
    logic               err_q, err_d;
    logic               code_illegal;
`endif

    logic               drain_ok;
    logic               out_fire;
    logic               idx_last;
    logic [NUM_OUT-1:0] code_onehot;

    // The output register counts as free when it is empty or is being
    // emptied this cycle. This lets a new word load without a bubble.
    assign drain_ok = !out_valid_q || out_ready;
    assign out_fire = out_valid_q && out_ready;
    assign idx_last = (idx_q == IN_W'(NUM_OUT - 1));

    // A code with no matching position sets no bit. An illegal code
    // (>= NUM_OUT) therefore decodes to all zeros with no extra logic.
    function automatic logic [NUM_OUT-1:0] decode(input logic [IN_W-1:0] code);
        logic [NUM_OUT-1:0] d;
        d = '0;
        for (int i = 0; i < NUM_OUT; i++) begin
            if (code == IN_W'(i)) begin
                d[i] = 1'b1;
            end
        end
        return d;
    endfunction

    assign code_onehot = decode(in_code);

`ifdef ONEHOT_DECODER_ERR_EN
    // The compare is one bit wider than the code, so NUM_OUT itself fits
    // even when NUM_OUT is a power of two.
    assign code_illegal = ({1'b0, in_code} >= (IN_W + 1)'(NUM_OUT));
`endif

    // State and datapath registers. All of them clear asynchronously, so a
    // reset during a sweep discards the partial sweep at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            idx_q       <= '0;
`ifdef ONEHOT_DECODER_ERR_EN
            err_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            idx_q       <= idx_d;
`ifdef ONEHOT_DECODER_ERR_EN
            err_q       <= err_d;
`endif
        end
    end

    // Next-state and next-word logic. By default every register holds.
    // While idle, sweep mode takes priority and the input stream is closed.
    // In a sweep, the hot bit shifts up on each output handshake. The
    // handshake on the last position ends the sweep and leaves out unchanged.
    always_comb begin
        state_d     = state_q;
        out_d       = out_q;
        out_valid_d = out_valid_q;
        idx_d       = idx_q;
`ifdef ONEHOT_DECODER_ERR_EN
        err_d       = err_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (mode && sweep_start && drain_ok) begin
                    state_d     = SWEEP;
                    idx_d       = '0;
                    out_d       = NUM_OUT'(1);
                    out_valid_d = 1'b1;
`ifdef ONEHOT_DECODER_ERR_EN
                    err_d       = 1'b0;
`endif
                end else if (!mode && in_valid && drain_ok) begin
                    out_d       = code_onehot;
                    out_valid_d = 1'b1;
`ifdef ONEHOT_DECODER_ERR_EN
                    err_d       = code_illegal;
`endif
                end else if (out_fire) begin
                    out_valid_d = 1'b0;
`ifdef ONEHOT_DECODER_ERR_EN
                    err_d       = 1'b0;
`endif
                end
            end
            SWEEP: begin
                if (out_fire) begin
                    if (idx_last) begin
                        state_d     = IDLE;
                        idx_d       = '0;
                        out_valid_d = 1'b0;
                    end else begin
                        idx_d = idx_q + 1'b1;
                        out_d = out_q << 1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs that depend on the state. The input side is open only in
    // direct mode while idle, and only when the output register can take
    // a word.
    always_comb begin
        in_ready = 1'b0;
        busy     = 1'b0;
        if (state_q == IDLE) begin
            in_ready = !mode && drain_ok;
        end else begin
            busy = 1'b1;
        end
    end

    assign out       = out_q;
    assign out_valid = out_valid_q;
`ifdef ONEHOT_DECODER_ERR_EN
    assign code_err  = err_q;
`endif

endmodule
